// File: rtl/priority_sensor_handler.sv
// Fixed-priority servicer for latched sensor interrupts: picks the lowest pending
// index, injects a one-flit event message via valid/ready, then pulses that latch's clear.
module priority_sensor_handler #(
  parameter int unsigned N_SENSOR = 4,
  parameter int unsigned ID_W     = 2,
  parameter logic [3:0]  NODE_ID  = 4'h0,
  parameter int unsigned FLIT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SENSOR-1:0] irq,
  output logic [N_SENSOR-1:0] irq_clr,
  output logic [FLIT_W-1:0]   flit_out,
  output logic                flit_valid,
  input  logic                flit_ready,
  output logic                busy
);

  localparam int unsigned SEQ_W       = 8;
  localparam int unsigned IDX_FIELD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CLEAR = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     idx, idx_d;
  logic [SEQ_W-1:0]    seq, seq_d;
  logic [FLIT_W-1:0]   flit_d;
  logic                valid_d;
  logic [N_SENSOR-1:0] clr_d;
  logic                busy_d;

  logic                irq_any;
  logic [ID_W-1:0]     irq_pick;

  // Lowest set bit wins; scanning downward lets the last hit be the smallest index.
  always_comb begin
    irq_pick = '0;
    for (int i = int'(N_SENSOR) - 1; i >= 0; i--) begin
      if (irq[i]) irq_pick = ID_W'(i);
    end
  end

  assign irq_any = |irq;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    seq_d   = seq;
    flit_d  = flit_out;
    valid_d = flit_valid;
    clr_d   = '0;

    case (state)
      IDLE: begin
        if (irq_any) begin
          idx_d   = irq_pick;
          flit_d  = FLIT_W'({NODE_ID, IDX_FIELD_W'(irq_pick), seq});
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (flit_ready) begin
          valid_d = 1'b0;
          clr_d   = N_SENSOR'(1) << idx;
          seq_d   = seq + SEQ_W'(1);
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Drain cycle: gives the cleared latch time to drop before the next pick.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      seq        <= '0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      irq_clr    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      seq        <= seq_d;
      flit_out   <= flit_d;
      flit_valid <= valid_d;
      irq_clr    <= clr_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_priority_sensor_handler.sv
// Scoreboard bench for priority_sensor_handler: a latch model feeds irq, expected
// flits/clears are queued at stimulus time and popped by an independent monitor.
module tb_priority_sensor_handler;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  irq = '0;
  logic [N-1:0]  irq_clr;
  logic [15:0]   flit_out;
  logic          flit_valid;
  logic          flit_ready = 1'b1;
  logic          busy;

  always #5 clk = ~clk;

  priority_sensor_handler #(
    .N_SENSOR (4),
    .ID_W     (2),
    .NODE_ID  (4'h5),
    .FLIT_W   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .irq_clr    (irq_clr),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .busy       (busy)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          xfer_cnt = 0;
  logic [15:0] exp_flit_q[$];
  logic [3:0]  exp_clr_q[$];
  logic [15:0] seen_q[$];
  logic [3:0]  set_pend  = '0;
  logic        wipe      = 1'b0;
  logic        rdy_rand  = 1'b0;
  logic        rdy_val   = 1'b1;
  logic [7:0]  model_seq = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Sensor latch model: set by stimulus, cleared by the handler's pulse; not reset by rst.
  always @(posedge clk) begin
    if (wipe) irq <= '0;
    else      irq <= (irq & ~irq_clr) | set_pend;
  end

  // Router-side ready, driven just after the active edge.
  always @(posedge clk) begin
    #1;
    flit_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Monitor: protocol invariants plus scoreboard pops on each transfer and clear pulse.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_flit = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("valid_held", 16'(flit_valid), 16'h1);
        check("flit_stable", flit_out, prev_flit);
      end
      if (irq_clr != '0) begin
        check("clr_onehot", 16'($onehot(irq_clr)), 16'h1);
        if (exp_clr_q.size() == 0) check("clr_unexpected", 16'(irq_clr), 16'h0);
        else check("clr_idx", 16'(irq_clr), 16'(exp_clr_q.pop_front()));
      end
      if (flit_valid && flit_ready) begin
        if (exp_flit_q.size() == 0) check("flit_unexpected", 16'(exp_flit_q.size()), 16'h1);
        else check("flit_data", flit_out, exp_flit_q.pop_front());
        seen_q.push_back(flit_out);
        xfer_cnt++;
      end
      prev_hold = flit_valid && !flit_ready;
      prev_flit = flit_out;
    end
  end

  task automatic raise(input logic [3:0] mask);
    @(negedge clk);
    set_pend = mask;
    @(negedge clk);
    set_pend = '0;
  endtask

  task automatic expect_mask(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        exp_flit_q.push_back({4'h5, 4'(i), model_seq});
        model_seq++;
        exp_clr_q.push_back(4'(1 << i));
      end
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!flit_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 16'(flit_valid), 16'h1);
  endtask

  task automatic wait_idle(input int budget);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy && irq == '0 && set_pend == '0 &&
          exp_flit_q.size() == 0 && exp_clr_q.size() == 0) quiet++;
      else quiet = 0;
    end
    check("idle_timeout", 16'(quiet >= 3), 16'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_flit_q.delete();
    exp_clr_q.delete();
    seen_q.delete();
    model_seq = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] mask;
    int         base;
    int         n;

    // Reset with all interrupts pending: everything stays quiet.
    set_pend = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_valid", 16'(flit_valid), 16'h0);
    check("rst_clr", 16'(irq_clr), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_flit", flit_out, 16'h0);
    set_pend = '0;
    wipe = 1'b1;
    @(negedge clk);
    wipe = 1'b0;
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_quiet", {flit_valid, busy, 2'b00, irq_clr, 8'h00} | flit_out, 16'h0);
    end

    // Single event on sensor 2 with latency/clear timing.
    do_reset();
    exp_flit_q.push_back(16'h5200);
    exp_clr_q.push_back(4'b0100);
    raise(4'b0100);
    wait_valid(10);
    check("t2_flit", flit_out, 16'h5200);
    check("t2_busy0", 16'(busy), 16'h1);
    @(negedge clk);
    check("t2_clr", 16'(irq_clr), 16'h0004);
    check("t2_valid_drop", 16'(flit_valid), 16'h0);
    @(negedge clk);
    check("t2_clr_once", 16'(irq_clr), 16'h0);
    check("t2_busy2", 16'(busy), 16'h1);
    @(negedge clk);
    check("t2_busy3", 16'(busy), 16'h0);
    wait_idle(50);

    // Two simultaneous interrupts served lowest index first.
    do_reset();
    exp_flit_q.push_back(16'h5100);
    exp_flit_q.push_back(16'h5301);
    exp_clr_q.push_back(4'b0010);
    exp_clr_q.push_back(4'b1000);
    raise(4'b1010);
    wait_idle(50);

    // Backpressure: flit held stable with no clear until ready.
    do_reset();
    rdy_val = 1'b0;
    exp_flit_q.push_back(16'h5000);
    exp_clr_q.push_back(4'b0001);
    raise(4'b0001);
    wait_valid(10);
    repeat (5) begin
      check("t4_flit", flit_out, 16'h5000);
      check("t4_valid", 16'(flit_valid), 16'h1);
      check("t4_noclr", 16'(irq_clr), 16'h0);
      @(negedge clk);
    end
    rdy_val = 1'b1;
    wait_idle(50);

    // Randomized interrupt sets under random backpressure.
    do_reset();
    rdy_rand = 1'b1;
    repeat (30) begin
      mask = 4'($urandom_range(1, 15));
      expect_mask(mask);
      raise(mask);
      wait_idle(300);
    end
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    wait_idle(50);

    // 257 back-to-back events on sensor 3: sequence wraps 255 -> 0.
    do_reset();
    for (int k = 0; k < 257; k++) expect_mask(4'b1000);
    base = xfer_cnt;
    set_pend = 4'b1000;
    n = 0;
    while (xfer_cnt < base + 257 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    set_pend = '0;
    check("t5_count", 16'(xfer_cnt - base), 16'd257);
    wait_idle(50);
    check("t5_seen", 16'(seen_q.size()), 16'd257);
    if (seen_q.size() >= 257) begin
      check("t5_seq255", 16'(seen_q[255][7:0]), 16'h00FF);
      check("t5_seq256", 16'(seen_q[256][7:0]), 16'h0000);
    end

    // Reset mid-SEND: flit abandoned immediately, latch re-served with seq 0.
    do_reset();
    rdy_val = 1'b0;
    raise(4'b0010);
    wait_valid(10);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_valid_async", 16'(flit_valid), 16'h0);
    check("t6_busy_async", 16'(busy), 16'h0);
    check("t6_irq_kept", 16'(irq), 16'h0002);
    repeat (3) @(negedge clk);
    check("t6_no_clr", 16'(irq_clr), 16'h0);
    exp_flit_q.push_back(16'h5100);
    exp_clr_q.push_back(4'b0010);
    rdy_val = 1'b1;
    rst = 1'b1;
    wait_idle(50);

    check("end_flit_q", 16'(exp_flit_q.size()), 16'h0);
    check("end_clr_q", 16'(exp_clr_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
